fuzz_round_sequencer: RTL and testbench

- Synthesizable controller that sequences fuzzing rounds on the SoC under test.
- Holds the core in reset and monitors each round for completion (tohost), timeout, coverage stall and watchdog. Raises the core software interrupt (msip) on stall or watchdog.
- Hands the round result to the coverage collector, requests a testcase memory reload, then restarts the core.
- Sits between TestHarness and the collector/loader, replacing testbench-side timing loops.

---
 rtl/fuzz_round_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fuzz_round_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_round_sequencer.sv
`default_nettype none
// ==== fuzz_round_sequencer : per-round hold/run/report/reload controller for the fuzzing SoC ====
// ==== rev 1.0 ====
module fuzz_round_sequencer #(
   parameter int unsigned     COV_W          = 30,
   parameter int unsigned     STALL_SHIFT    = 19,
   parameter longint unsigned MAX_WAIT       = 1000,
   parameter longint unsigned WATCHDOG_LIMIT = 50000,
   parameter longint unsigned MAX_CYCLES     = 2000000000,
   parameter int unsigned     RESET_HOLD     = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [COV_W-1:0] cov,
   input  logic [63:0]      tohost,
   input  logic             status_ready,
   input  logic             status_continue,
   input  logic             reload_ack,
   output logic             core_reset,
   output logic             interrupt,
   output logic             status_valid,
   output logic [1:0]       status_code,
   output logic [63:0]      status_cycles,
   output logic [COV_W-1:0] status_cov,
   output logic             reload_req,
   output logic [31:0]      round_count,
   output logic             halted
);

   typedef enum logic [2:0] {
      ST_HOLD   = 3'd0,
      ST_RUN    = 3'd1,
      ST_REPORT = 3'd2,
      ST_RELOAD = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   localparam logic [31:0] HOLD_LAST = 32'(RESET_HOLD - 1);
   localparam logic [63:0] MAX_CYC   = 64'(MAX_CYCLES);
   localparam logic [63:0] WD_LIMIT  = 64'(WATCHDOG_LIMIT);

   state_t           state_q, state_d;
   logic [31:0]      hold_cnt_q, hold_cnt_d;
   logic [63:0]      round_cycles_q, round_cycles_d;
   logic [63:0]      stall_cnt_q, stall_cnt_d;
   logic [63:0]      watchdog_q, watchdog_d;
   logic [COV_W-1:0] pre_cov_q, pre_cov_d;
   logic [31:0]      round_count_q, round_count_d;
   logic [1:0]       status_code_q, status_code_d;
   logic [63:0]      status_cycles_q, status_cycles_d;
   logic [COV_W-1:0] status_cov_q, status_cov_d;
   logic [63:0]      stall_thresh;
   logic             unused_tohost_bits;

   // Only the pass bit of tohost matters to the sequencer.
   assign unused_tohost_bits = ^tohost[63:1];
   assign stall_thresh = 64'(MAX_WAIT) * (64'(cov >> STALL_SHIFT) + 64'd1);

   function automatic logic [63:0] inc64(input logic [63:0] v);
      return (&v) ? v : v + 64'd1;
   endfunction

   function automatic logic [31:0] inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= ST_HOLD;
         hold_cnt_q      <= '0;
         round_cycles_q  <= '0;
         stall_cnt_q     <= '0;
         watchdog_q      <= '0;
         pre_cov_q       <= '0;
         round_count_q   <= '0;
         status_code_q   <= '0;
         status_cycles_q <= '0;
         status_cov_q    <= '0;
      end else begin
         state_q         <= state_d;
         hold_cnt_q      <= hold_cnt_d;
         round_cycles_q  <= round_cycles_d;
         stall_cnt_q     <= stall_cnt_d;
         watchdog_q      <= watchdog_d;
         pre_cov_q       <= pre_cov_d;
         round_count_q   <= round_count_d;
         status_code_q   <= status_code_d;
         status_cycles_q <= status_cycles_d;
         status_cov_q    <= status_cov_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      hold_cnt_d      = hold_cnt_q;
      round_cycles_d  = round_cycles_q;
      stall_cnt_d     = stall_cnt_q;
      watchdog_d      = watchdog_q;
      pre_cov_d       = pre_cov_q;
      round_count_d   = round_count_q;
      status_code_d   = status_code_q;
      status_cycles_d = status_cycles_q;
      status_cov_d    = status_cov_q;
      core_reset      = 1'b1;
      interrupt       = 1'b0;
      status_valid    = 1'b0;
      reload_req      = 1'b0;
      halted          = 1'b0;

      case (state_q)
         ST_HOLD: begin
            hold_cnt_d = inc32(hold_cnt_q);
            if (hold_cnt_q == HOLD_LAST) begin
               state_d        = ST_RUN;
               round_cycles_d = '0;
               stall_cnt_d    = '0;
               watchdog_d     = '0;
               pre_cov_d      = '0;
            end
         end
         ST_RUN: begin
            core_reset     = 1'b0;
            interrupt      = (stall_cnt_q >= stall_thresh) || (watchdog_q >= WD_LIMIT);
            round_cycles_d = inc64(round_cycles_q);
            if (cov != pre_cov_q) begin
               pre_cov_d   = cov;
               stall_cnt_d = '0;
            end else begin
               stall_cnt_d = inc64(stall_cnt_q);
            end
            watchdog_d = tohost[0] ? 64'd0 : inc64(watchdog_q);
            // Pass is tested first so it wins over a coincident timeout.
            if (tohost[0] || (round_cycles_q >= MAX_CYC)) begin
               state_d         = ST_REPORT;
               status_code_d   = tohost[0] ? 2'd0 : 2'd1;
               status_cycles_d = inc64(round_cycles_q);
               status_cov_d    = cov;
            end
         end
         ST_REPORT: begin
            status_valid = 1'b1;
            if (status_ready) begin
               round_count_d = inc32(round_count_q);
               state_d       = status_continue ? ST_RELOAD : ST_HALT;
            end
         end
         ST_RELOAD: begin
            reload_req = 1'b1;
            if (reload_ack) begin
               state_d    = ST_HOLD;
               hold_cnt_d = '0;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
   end

   assign status_code   = status_code_q;
   assign status_cycles = status_cycles_q;
   assign status_cov    = status_cov_q;
   assign round_count   = round_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fuzz_round_sequencer.sv
`default_nettype none
// ==== tb_fuzz_round_sequencer : randomized self-checking bench for fuzz_round_sequencer ====
// ==== rev 1.0 ====
module tb_fuzz_round_sequencer;
   localparam int     P_COV_W    = 30;
   localparam int     P_SHIFT    = 2;
   localparam longint P_MAX_WAIT = 4;
   localparam longint P_WDL      = 20;
   localparam int     P_MAXC     = 120;
   localparam int     P_HOLD     = 8;

   logic               clock = 1'b0;
   logic               reset;
   logic [P_COV_W-1:0] cov;
   logic [63:0]        tohost;
   logic               status_ready;
   logic               status_continue;
   logic               reload_ack;
   logic               core_reset;
   logic               interrupt;
   logic               status_valid;
   logic [1:0]         status_code;
   logic [63:0]        status_cycles;
   logic [P_COV_W-1:0] status_cov;
   logic               reload_req;
   logic [31:0]        round_count;
   logic               halted;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   fuzz_round_sequencer #(
      .COV_W(P_COV_W), .STALL_SHIFT(P_SHIFT), .MAX_WAIT(P_MAX_WAIT),
      .WATCHDOG_LIMIT(P_WDL), .MAX_CYCLES(P_MAXC), .RESET_HOLD(P_HOLD)
   ) dut (
      .clock(clock), .reset(reset), .cov(cov), .tohost(tohost),
      .status_ready(status_ready), .status_continue(status_continue),
      .reload_ack(reload_ack), .core_reset(core_reset), .interrupt(interrupt),
      .status_valid(status_valid), .status_code(status_code),
      .status_cycles(status_cycles), .status_cov(status_cov),
      .reload_req(reload_req), .round_count(round_count), .halted(halted)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag, input bit exp_halt, input bit exp_reload,
                             input bit exp_valid);
      check({tag, ".core_reset"}, 64'(core_reset), 64'd1);
      check({tag, ".interrupt"}, 64'(interrupt), 64'd0);
      check({tag, ".status_valid"}, 64'(status_valid), 64'(exp_valid));
      check({tag, ".halted"}, 64'(halted), 64'(exp_halt));
      check({tag, ".reload_req"}, 64'(reload_req), 64'(exp_reload));
   endtask

   task automatic check_reset_vals(input string tag);
      check_idle(tag, 1'b0, 1'b0, 1'b0);
      check({tag, ".status_code"}, 64'(status_code), 64'd0);
      check({tag, ".status_cycles"}, status_cycles, 64'd0);
      check({tag, ".status_cov"}, 64'(status_cov), 64'd0);
      check({tag, ".round_count"}, 64'(round_count), 64'd0);
   endtask

   // Eight cycles of core_reset with junk on the ignored inputs.
   task automatic hold_phase();
      for (int i = 0; i < P_HOLD; i++) begin
         @(negedge clock);
         reload_ack   = 1'($urandom_range(0, 1));
         status_ready = 1'($urandom_range(0, 1));
         tohost       = {$urandom(), $urandom()};
         #1;
         check_idle("hold", 1'b0, 1'b0, 1'b0);
      end
      @(negedge clock);
      reload_ack = 1'b0;
   endtask

   // Reference: stall = cycles since the last cov change (cov starts at 0),
   // watchdog = round age because any tohost pass ends the round.
   task automatic run_round(input int mode, input int pass_at, output int k_exit,
                            output logic [P_COV_W-1:0] cov_exit, output bit passed);
      logic [P_COV_W-1:0] prev = '0;
      logic [P_COV_W-1:0] c;
      longint lc = -1;
      longint stall, thr;
      int k = 0;
      bit done = 1'b0;
      bit exp_int;
      while (!done) begin
         if (k != 0) @(negedge clock);
         case (mode)
            0:       c = ($urandom_range(0, 3) == 0) ? P_COV_W'($urandom_range(0, 63)) : prev;
            1:       c = (k < 12) ? P_COV_W'(4) : P_COV_W'(5);
            default: c = (k % 2 == 1) ? P_COV_W'(1) : P_COV_W'(2);
         endcase
         cov          = c;
         tohost       = {$urandom(), $urandom()};
         tohost[0]    = (k == pass_at);
         reload_ack   = 1'($urandom_range(0, 1));
         status_ready = 1'($urandom_range(0, 1));
         #1;
         stall   = longint'(k) - 1 - lc;
         thr     = P_MAX_WAIT * (longint'(c >> P_SHIFT) + 1);
         exp_int = (stall >= thr) || (longint'(k) >= P_WDL);
         check("run.core_reset", 64'(core_reset), 64'd0);
         check("run.interrupt", 64'(interrupt), 64'(exp_int));
         check("run.status_valid", 64'(status_valid), 64'd0);
         if (c != prev) lc = k;
         if (k == pass_at || k >= P_MAXC) begin
            done     = 1'b1;
            k_exit   = k;
            cov_exit = c;
            passed   = (k == pass_at);
         end
         prev = c;
         k++;
      end
   endtask

   task automatic report_window(input int k_exit, input logic [P_COV_W-1:0] cov_exit,
                                input bit passed, input int rc);
      check_idle("report", 1'b0, 1'b0, 1'b1);
      check("report.status_code", 64'(status_code), passed ? 64'd0 : 64'd1);
      check("report.status_cycles", status_cycles, 64'(k_exit + 1));
      check("report.status_cov", 64'(status_cov), 64'(cov_exit));
      check("report.round_count", 64'(round_count), 64'(rc));
   endtask

   task automatic report(input int k_exit, input logic [P_COV_W-1:0] cov_exit, input bit passed,
                         input int wait_n, input bit cont, input int rc);
      for (int i = 0; i < wait_n; i++) begin
         @(negedge clock);
         status_ready    = 1'b0;
         status_continue = 1'($urandom_range(0, 1));
         reload_ack      = 1'($urandom_range(0, 1));
         #1;
         report_window(k_exit, cov_exit, passed, rc);
      end
      @(negedge clock);
      status_ready    = 1'b1;
      status_continue = cont;
      reload_ack      = 1'($urandom_range(0, 1));
      #1;
      report_window(k_exit, cov_exit, passed, rc);
      @(negedge clock);
      status_ready = 1'b0;
      reload_ack   = 1'b0;
      #1;
      check_idle("post_report", !cont, cont, 1'b0);
      check("post_report.round_count", 64'(round_count), 64'(rc + 1));
   endtask

   task automatic reload_phase(input int n_wait);
      for (int i = 0; i < n_wait; i++) begin
         @(negedge clock);
         reload_ack = 1'b0;
         #1;
         check_idle("reload", 1'b0, 1'b1, 1'b0);
      end
      @(negedge clock);
      reload_ack = 1'b1;
      #1;
      check_idle("reload_ack", 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within its time bound");
      $fatal(1, "time bound exceeded");
   end

   initial begin
      int ke;
      logic [P_COV_W-1:0] ce;
      bit ps;
      reset = 1'b1; cov = '0; tohost = '0;
      status_ready = 1'b0; status_continue = 1'b0; reload_ack = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_reset_vals("reset");
      #1 reset = 1'b0;
      hold_phase();

      // Random coverage, pass at a random cycle, continue.
      run_round(0, int'($urandom_range(30, 100)), ke, ce, ps);
      report(ke, ce, ps, int'($urandom_range(0, 3)), 1'b1, 0);
      reload_phase(int'($urandom_range(0, 4)));
      hold_phase();

      // Coverage stuck at 4 (threshold 8), then bumped to 5.
      run_round(1, 15, ke, ce, ps);
      report(ke, ce, ps, int'($urandom_range(0, 3)), 1'b1, 1);
      reload_phase(int'($urandom_range(0, 4)));
      hold_phase();

      // Coverage toggling every cycle, watchdog fires at 20, pass at 25.
      run_round(2, 25, ke, ce, ps);
      report(ke, ce, ps, int'($urandom_range(0, 3)), 1'b1, 2);
      reload_phase(0);
      hold_phase();

      // Pass coinciding with timeout, then stop.
      run_round(0, P_MAXC, ke, ce, ps);
      report(ke, ce, ps, 1, 1'b0, 3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         status_ready = 1'b1; status_continue = 1'b1; reload_ack = 1'b1;
         tohost = 64'd1;
         #1;
         check_idle("halt", 1'b1, 1'b0, 1'b0);
         check("halt.round_count", 64'(round_count), 64'd4);
      end

      @(negedge clock);
      status_ready = 1'b0; reload_ack = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_reset_vals("reset_from_halt");
      @(posedge clock);
      #2 reset = 1'b0;
      hold_phase();

      // Pure timeout round, then reset while the report is pending.
      run_round(0, -1, ke, ce, ps);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         status_ready = 1'b0;
         #1;
         report_window(ke, ce, ps, 0);
      end
      #1 reset = 1'b1;
      #1;
      check_reset_vals("reset_mid_report");
      @(posedge clock);
      #2 reset = 1'b0;
      hold_phase();
      cov = '0; tohost = '0;
      #1;
      check("restart.core_reset", 64'(core_reset), 64'd0);
      check("restart.round_count", 64'(round_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
